ex_div: RTL

EX_DIV -- requirements
Module: ex_div

---
 rtl/ex_div.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/ex_div.sv
// rtl/ex_div.sv - 32-bit multi-cycle restoring divider for the EX stage (signed support under DIV_SIGNED_EN)
module ex_div (
    input  logic        clk,
    input  logic        rst,
    input  logic        signed_div_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    input  logic        start_i,
    input  logic        annul_i,
    output logic [63:0] result_o,
    output logic        ready_o
);

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BYZERO = 2'd1,
        ON     = 2'd2,
        END    = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [64:0] work_q, work_d;
    logic [31:0] dvs_q, dvs_d;
    logic [63:0] result_d;
    logic        ready_d;

    logic [31:0] dvd_abs, dvs_abs;
    logic [31:0] quo_fix, rem_fix;
    logic        accept;

    logic [64:0] shifted;
    logic [32:0] diff;
    logic [64:0] step;
    logic        unused_work_msb;

    assign accept = (state_q == FREE) && start_i && !annul_i && (opdata2_i != 32'd0);

    // Partial remainder never reaches the divisor, so the working register's MSB is always 0.
    assign unused_work_msb = work_q[64];
    assign shifted = {work_q[63:0], 1'b0};
    assign diff    = shifted[64:32] - {1'b0, dvs_q};
    assign step    = diff[32] ? shifted : {diff, shifted[31:1], 1'b1};

`ifdef DIV_SIGNED_EN
    logic dvd_neg, dvs_neg;
    logic neg_quo_q, neg_rem_q;

    assign dvd_neg = signed_div_i & opdata1_i[31];
    assign dvs_neg = signed_div_i & opdata2_i[31];
    assign dvd_abs = dvd_neg ? (~opdata1_i + 32'd1) : opdata1_i;
    assign dvs_abs = dvs_neg ? (~opdata2_i + 32'd1) : opdata2_i;
    assign quo_fix = neg_quo_q ? (~step[31:0] + 32'd1) : step[31:0];
    assign rem_fix = neg_rem_q ? (~step[63:32] + 32'd1) : step[63:32];

    always_ff @(posedge clk) begin
        if (rst) begin
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
        end else if (accept) begin
            neg_quo_q <= dvd_neg ^ dvs_neg;
            neg_rem_q <= dvd_neg;
        end
    end
`else
    logic unused_signed;

    assign unused_signed = signed_div_i;
    assign dvd_abs = opdata1_i;
    assign dvs_abs = opdata2_i;
    assign quo_fix = step[31:0];
    assign rem_fix = step[63:32];
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= FREE;
            cnt_q    <= 6'd0;
            work_q   <= 65'd0;
            dvs_q    <= 32'd0;
            result_o <= 64'd0;
            ready_o  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            work_q   <= work_d;
            dvs_q    <= dvs_d;
            result_o <= result_d;
            ready_o  <= ready_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        work_d   = work_q;
        dvs_d    = dvs_q;
        result_d = result_o;
        ready_d  = ready_o;
        case (state_q)
            FREE: begin
                result_d = 64'd0;
                ready_d  = 1'b0;
                if (start_i && !annul_i) begin
                    if (opdata2_i == 32'd0) begin
                        state_d = BYZERO;
                    end else begin
                        state_d = ON;
                        cnt_d   = 6'd0;
                        work_d  = {33'd0, dvd_abs};
                        dvs_d   = dvs_abs;
                    end
                end
            end
            BYZERO: begin
                if (annul_i) begin
                    state_d  = FREE;
                    result_d = 64'd0;
                    ready_d  = 1'b0;
                end else begin
                    state_d  = END;
                    result_d = 64'd0;
                    ready_d  = 1'b1;
                end
            end
            ON: begin
                if (annul_i) begin
                    state_d  = FREE;
                    result_d = 64'd0;
                    ready_d  = 1'b0;
                end else begin
                    work_d = step;
                    cnt_d  = cnt_q + 6'd1;
                    if (cnt_q == 6'd31) begin
                        state_d  = END;
                        result_d = {rem_fix, quo_fix};
                        ready_d  = 1'b1;
                    end
                end
            end
            END: begin
                if (annul_i || !start_i) begin
                    state_d  = FREE;
                    result_d = 64'd0;
                    ready_d  = 1'b0;
                end
            end
            default: state_d = FREE;
        endcase
    end

endmodule
